adc_pulse_train_generator: RTL and testbench
============================================

// Module: adc_pulse_train_generator
// PURPOSE
//  Synthesises a stream of signed ADC-format samples containing rectangular pulses.
//  Each pulse is a programmable amplitude, width, period and count, and sits on a baseline.
//  It is the transmit-side counterpart of the threshold pulse counter.
//  Its AXI-Stream master output drives the counter's ADC sample input, for closed-loop
//  bring-up and for regression of threshold/counting logic without live photon signals.
// PARAMETERS
//  ADC_WIDTH         14  width of the signed sample carried in the low bits of tdata
//  COUNT_WIDTH       32  width of the period, pulse-count and pulses_sent fields
//  WIDTH_BITS        16  width of the pulse_width field
//  AXIS_TDATA_WIDTH  32  output tdata width; the sample is sign-extended to this width
// PORTS
//  clk                clk   in   1                 system clock (125 MHz)
//  rst                rst   in   1                 synchronous, active-low reset
//  start              in   1                 1-cycle request to begin a train (honoured only in IDLE)
//  stop               in   1                 request to end a continuous/long train early
//  period             in   COUNT_WIDTH       cycles (accepted samples) from one pulse start to the next
//  pulse_width        in   WIDTH_BITS        number of HIGH samples per pulse
//  amplitude          in   ADC_WIDTH signed  sample value during HIGH
//  baseline           in   ADC_WIDTH signed  sample value during LOW
//  n_pulses           in   COUNT_WIDTH       pulses to emit; 0 = continuous until stop
//  M_AXIS_OUT_tdata   out  AXIS_TDATA_WIDTH  sign-extended sample
//  M_AXIS_OUT_tvalid  out  1                 sample valid
//  M_AXIS_OUT_tready  in   1                 downstream accept
//  busy               out  1                 train in progress
//  done               out  1                 1-cycle strobe when a train ends
//  pulses_sent        out  COUNT_WIDTH       pulses completed in the current/last train
// BEHAVIOUR
//  - Reset (rst==0 at a clk edge): state=IDLE, tdata=0, tvalid=0, busy=0, done=0,
//    pulses_sent=0, and the stop latch is cleared.
//    Reset mid-train aborts immediately; it overrides start and stop.
//  - All outputs are registered.
//  - Config latching:
//    - start in IDLE latches period, pulse_width, amplitude, baseline and n_pulses.
//    - Input changes while busy are ignored until the next start.
//    - start while busy is ignored.
//  - Width clamping, applied at latch time:
//    - eff_width = max(pulse_width, 1).
//    - eff_period = max(period, eff_width+1), so at least 1 LOW sample per pulse.
//  - FSM states: IDLE, HIGH, LOW, DONE.
//    - IDLE: on start, go to HIGH; clear pulses_sent; set busy=1.
//    - HIGH: tvalid=1, tdata=sxt(amplitude).
//      After eff_width accepted samples, go to LOW and increment pulses_sent.
//    - LOW: tvalid=1, tdata=sxt(baseline).
//      After (eff_period - eff_width) accepted samples:
//      - go to DONE if (n_pulses!=0 && pulses_sent==n_pulses) or the stop latch is set;
//      - otherwise go to HIGH.
//    - DONE: tvalid=0, done=1 for exactly one cycle, busy=0, then go to IDLE.
//      pulses_sent holds until the next start.
//  - Latency: start sampled at edge N gives tvalid=1 with the first amplitude sample at edge N+1.
//  - Handshake: a sample is consumed only when tvalid && tready.
//    - While tvalid=1 && tready=0, tdata is held stable and the sample counters freeze.
//    - No sample is dropped or duplicated.
//  - stop: latched when busy. The current pulse and its LOW tail are completed; then DONE.
//    stop in IDLE is ignored.
//  - Counters: the in-phase sample counter is COUNT_WIDTH wide.
//    pulses_sent wraps modulo 2^COUNT_WIDTH in continuous mode. No other wrap is permitted.
//  - Simultaneous start and stop in IDLE: start wins; stop is not latched,
//    because it is only captured when busy.
// TESTING
//  1. period=10, width=3, amp=600, base=0, n=2, tready=1 -> samples 600x3, 0x7, 600x3, 0x7;
//     done strobes 1 cycle after the 20th sample; pulses_sent=2.
//  2. As 1, with tready toggling 1,0,1,0 -> identical accepted sequence;
//     tdata stable while tready=0; no drops or duplicates.
//  3. width=0, period=0, amp=-100, base=5, n=3 -> (-100, 5) x3; pulses_sent=3.
//  4. n=0, width=2, period=6, stop pulsed during the 2nd pulse's HIGH ->
//     the 2nd pulse's LOW tail (4 samples) is completed, then done; pulses_sent=2.
//  5. rst=0 during HIGH -> next edge: tvalid=0, tdata=0, busy=0, pulses_sent=0;
//     start while rst=0 has no effect.
//  6. start while busy, with amplitude changed mid-train -> ignored;
//     the running train keeps the latched values; a new start after done uses the new values.

Source files
------------

// File: rtl/adc_pulse_train_generator.sv
// Rectangular pulse-train synthesiser emitting sign-extended ADC samples on an
// AXI-Stream master. Amplitude, baseline, width, period and count are latched on start.
module adc_pulse_train_generator #(
  parameter int ADC_WIDTH        = 14,
  parameter int COUNT_WIDTH      = 32,
  parameter int WIDTH_BITS       = 16,
  parameter int AXIS_TDATA_WIDTH = 32
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic                        stop,
  input  logic [COUNT_WIDTH-1:0]      period,
  input  logic [WIDTH_BITS-1:0]       pulse_width,
  input  logic signed [ADC_WIDTH-1:0] amplitude,
  input  logic signed [ADC_WIDTH-1:0] baseline,
  input  logic [COUNT_WIDTH-1:0]      n_pulses,
  output logic [AXIS_TDATA_WIDTH-1:0] M_AXIS_OUT_tdata,
  output logic                        M_AXIS_OUT_tvalid,
  input  logic                        M_AXIS_OUT_tready,
  output logic                        busy,
  output logic                        done,
  output logic [COUNT_WIDTH-1:0]      pulses_sent
);

  localparam int EXT = AXIS_TDATA_WIDTH - ADC_WIDTH;
  localparam logic [COUNT_WIDTH-1:0] CNT_ONE = COUNT_WIDTH'(1);

  typedef enum logic [1:0] {S_IDLE, S_HIGH, S_LOW, S_DONE} state_t;

  state_t                        state_q, state_d;
  logic [COUNT_WIDTH-1:0]        cnt_q, cnt_d;
  logic [COUNT_WIDTH-1:0]        hi_len_q, hi_len_d;
  logic [COUNT_WIDTH-1:0]        lo_len_q, lo_len_d;
  logic [COUNT_WIDTH-1:0]        n_q, n_d;
  logic signed [ADC_WIDTH-1:0]   amp_q, amp_d;
  logic signed [ADC_WIDTH-1:0]   base_q, base_d;
  logic                          stop_q, stop_d;
  logic [AXIS_TDATA_WIDTH-1:0]   tdata_q, tdata_d;
  logic                          tvalid_q, tvalid_d;
  logic                          busy_q, busy_d;
  logic                          done_q, done_d;
  logic [COUNT_WIDTH-1:0]        sent_q, sent_d;

  logic [WIDTH_BITS-1:0]         eff_w;
  logic [COUNT_WIDTH-1:0]        eff_w_c, min_period, eff_p;
  logic                          accept;

  function automatic logic [AXIS_TDATA_WIDTH-1:0] sxt(input logic signed [ADC_WIDTH-1:0] v);
    return {{EXT{v[ADC_WIDTH-1]}}, v};
  endfunction

  // Clamp so every pulse has at least one HIGH and one LOW sample.
  assign eff_w      = (pulse_width == '0) ? WIDTH_BITS'(1) : pulse_width;
  assign eff_w_c    = COUNT_WIDTH'(eff_w);
  assign min_period = eff_w_c + CNT_ONE;
  assign eff_p      = (period > min_period) ? period : min_period;
  assign accept     = tvalid_q & M_AXIS_OUT_tready;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    hi_len_d = hi_len_q;
    lo_len_d = lo_len_q;
    n_d      = n_q;
    amp_d    = amp_q;
    base_d   = base_q;
    stop_d   = stop_q | (busy_q & stop);
    tdata_d  = tdata_q;
    tvalid_d = tvalid_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    sent_d   = sent_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d  = S_HIGH;
          hi_len_d = eff_w_c;
          lo_len_d = eff_p - eff_w_c;
          n_d      = n_pulses;
          amp_d    = amplitude;
          base_d   = baseline;
          cnt_d    = '0;
          sent_d   = '0;
          stop_d   = 1'b0;
          busy_d   = 1'b1;
          tvalid_d = 1'b1;
          tdata_d  = sxt(amplitude);
        end
      end
      S_HIGH: begin
        if (accept) begin
          if (cnt_q == hi_len_q - CNT_ONE) begin
            state_d = S_LOW;
            cnt_d   = '0;
            sent_d  = sent_q + CNT_ONE;
            tdata_d = sxt(base_q);
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
      end
      S_LOW: begin
        if (accept) begin
          if (cnt_q == lo_len_q - CNT_ONE) begin
            cnt_d = '0;
            // The end-of-train decision uses the stop already latched before this edge.
            if (((n_q != '0) && (sent_q == n_q)) || stop_q) begin
              state_d  = S_DONE;
              tvalid_d = 1'b0;
              busy_d   = 1'b0;
              done_d   = 1'b1;
              stop_d   = 1'b0;
            end else begin
              state_d = S_HIGH;
              tdata_d = sxt(amp_q);
            end
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      hi_len_q <= '0;
      lo_len_q <= '0;
      n_q      <= '0;
      amp_q    <= '0;
      base_q   <= '0;
      stop_q   <= 1'b0;
      tdata_q  <= '0;
      tvalid_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      sent_q   <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hi_len_q <= hi_len_d;
      lo_len_q <= lo_len_d;
      n_q      <= n_d;
      amp_q    <= amp_d;
      base_q   <= base_d;
      stop_q   <= stop_d;
      tdata_q  <= tdata_d;
      tvalid_q <= tvalid_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      sent_q   <= sent_d;
    end
  end

  assign M_AXIS_OUT_tdata  = tdata_q;
  assign M_AXIS_OUT_tvalid = tvalid_q;
  assign busy              = busy_q;
  assign done              = done_q;
  assign pulses_sent       = sent_q;

endmodule

// File: tb/tb_adc_pulse_train_generator.sv
// Bench for adc_pulse_train_generator: directed scenarios plus randomized trains,
// checked every cycle against an arithmetic sample-index model of the pulse train.
module tb_adc_pulse_train_generator;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic               start = 1'b0;
  logic               stop = 1'b0;
  logic [31:0]        period = '0;
  logic [15:0]        pulse_width = '0;
  logic signed [13:0] amplitude = '0;
  logic signed [13:0] baseline = '0;
  logic [31:0]        n_pulses = '0;
  logic [31:0]        tdata;
  logic               tvalid;
  logic               tready = 1'b1;
  logic               busy;
  logic               done;
  logic [31:0]        pulses_sent;

  adc_pulse_train_generator dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .period(period),
    .pulse_width(pulse_width), .amplitude(amplitude), .baseline(baseline),
    .n_pulses(n_pulses), .M_AXIS_OUT_tdata(tdata), .M_AXIS_OUT_tvalid(tvalid),
    .M_AXIS_OUT_tready(tready), .busy(busy), .done(done), .pulses_sent(pulses_sent)
  );

  always #4 clk = ~clk;

  int tests  = 0;
  int errors = 0;

  // Model: a train is described by its latched parameters and the number of
  // samples accepted so far; sample k is HIGH when (k mod P) < W.
  logic        m_active = 1'b0;
  logic        m_stop   = 1'b0;
  longint      m_k = 0, m_w = 1, m_p = 2, m_n = 0;
  logic [31:0] m_amp = '0, m_base = '0;
  logic        e_valid = 1'b0, e_busy = 1'b0, e_done = 1'b0;
  logic [31:0] e_data = '0, e_sent = '0;

  logic [31:0] acc[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic longint pulses_done(input longint k);
    return (k < m_w) ? 0 : (k - m_w) / m_p + 1;
  endfunction

  task automatic model_step();
    logic stop_next;
    if (!rst) begin
      m_active = 1'b0; m_stop = 1'b0;
      e_valid = 1'b0; e_busy = 1'b0; e_done = 1'b0; e_data = '0; e_sent = '0;
    end else if (e_done) begin
      e_done = 1'b0;
    end else if (!m_active) begin
      if (start) begin
        m_w   = (pulse_width == 0) ? 1 : longint'(pulse_width);
        m_p   = (longint'(period) > m_w) ? longint'(period) : m_w + 1;
        m_n   = longint'(n_pulses);
        m_amp = int'(amplitude);
        m_base = int'(baseline);
        m_k = 0; m_active = 1'b1; m_stop = 1'b0;
        e_valid = 1'b1; e_busy = 1'b1; e_sent = '0; e_data = m_amp;
      end
    end else begin
      stop_next = m_stop | stop;
      if (tready) begin
        m_k++;
        e_sent = 32'(pulses_done(m_k));
        if ((m_k % m_p == 0) && (((m_n != 0) && (pulses_done(m_k) == m_n)) || m_stop)) begin
          m_active = 1'b0; stop_next = 1'b0;
          e_valid = 1'b0; e_busy = 1'b0; e_done = 1'b1;
        end else begin
          e_data = ((m_k % m_p) < m_w) ? m_amp : m_base;
        end
      end
      m_stop = stop_next;
    end
  endtask

  task automatic tick();
    model_step();
    if (rst && tvalid && tready) acc.push_back(tdata);
    @(posedge clk);
    #1;
    check("tvalid", 64'(tvalid), 64'(e_valid));
    check("busy", 64'(busy), 64'(e_busy));
    check("done", 64'(done), 64'(e_done));
    check("pulses_sent", 64'(pulses_sent), 64'(e_sent));
    if (e_valid) check("tdata", 64'(tdata), 64'(e_data));
  endtask

  task automatic launch(input int per, input int w, input int amp, input int base, input int n);
    period = 32'(per); pulse_width = 16'(w); amplitude = 14'(amp);
    baseline = 14'(base); n_pulses = 32'(n);
    acc.delete();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic run_to_done(input string name, input int limit, output int cycles);
    cycles = 0;
    while (!e_done && cycles < limit) begin
      tick();
      cycles++;
    end
    if (!e_done) check({name, "_timeout"}, 64'(cycles), 64'(limit + 1));
    tick();
  endtask

  task automatic expect_seq(input string name, input int reps, input int hi_n, input int hi_v,
                            input int lo_n, input int lo_v);
    logic [31:0] exp_q[$];
    for (int r = 0; r < reps; r++) begin
      for (int i = 0; i < hi_n; i++) exp_q.push_back(hi_v);
      for (int i = 0; i < lo_n; i++) exp_q.push_back(lo_v);
    end
    check({name, "_len"}, 64'(acc.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < acc.size(); i++)
      check({name, "_sample"}, 64'(acc[i]), 64'(exp_q[i]));
  endtask

  initial begin
    int cyc;
    tick(); tick();
    check("reset_tdata", 64'(tdata), 64'd0);
    check("reset_tvalid", 64'(tvalid), 64'd0);
    check("reset_sent", 64'(pulses_sent), 64'd0);
    rst = 1'b1;
    tick();

    // 1: basic train with always-ready sink
    tready = 1'b1;
    launch(10, 3, 600, 0, 2);
    run_to_done("t1", 100, cyc);
    check("t1_done_latency", 64'(cyc), 64'd20);
    expect_seq("t1", 2, 3, 600, 7, 0);
    check("t1_sent", 64'(pulses_sent), 64'd2);

    // 2: same train under backpressure
    launch(10, 3, 600, 0, 2);
    for (int i = 0; i < 200 && !e_done; i++) begin
      tready = i[0] ? 1'b1 : 1'b0;
      tick();
    end
    tready = 1'b1;
    run_to_done("t2", 10, cyc);
    expect_seq("t2", 2, 3, 600, 7, 0);

    // 3: zero width and period clamp to one HIGH and one LOW sample
    launch(0, 0, -100, 5, 3);
    run_to_done("t3", 50, cyc);
    expect_seq("t3", 3, 1, 32'hFFFF_FF9C, 1, 5);
    check("t3_sent", 64'(pulses_sent), 64'd3);

    // 4: continuous train stopped during the second pulse's HIGH phase
    launch(6, 2, 300, -7, 0);
    repeat (6) tick();
    stop = 1'b1;
    tick();
    stop = 1'b0;
    run_to_done("t4", 50, cyc);
    expect_seq("t4", 2, 2, 300, 4, 32'hFFFF_FFF9);
    check("t4_sent", 64'(pulses_sent), 64'd2);

    // 5: reset mid-HIGH aborts and overrides start
    launch(8, 4, 1234, 0, 3);
    tick();
    rst = 1'b0; start = 1'b1;
    tick();
    check("t5_tvalid", 64'(tvalid), 64'd0);
    check("t5_tdata", 64'(tdata), 64'd0);
    check("t5_busy", 64'(busy), 64'd0);
    tick();
    check("t5_hold_busy", 64'(busy), 64'd0);
    rst = 1'b1; start = 1'b0;
    tick();
    check("t5_idle_after", 64'(tvalid), 64'd0);

    // 6: start and config changes while busy are ignored
    launch(4, 2, 1000, 7, 2);
    tick(); tick();
    amplitude = -14'sd2000;
    start = 1'b1;
    tick();
    start = 1'b0;
    run_to_done("t6", 50, cyc);
    expect_seq("t6", 2, 2, 1000, 2, 7);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("t6_new_amp", 64'(tdata), 64'h0000_0000_FFFF_F830);
    run_to_done("t6b", 50, cyc);

    // Randomized trains with random backpressure, stop, start noise and rare resets
    for (int c = 0; c < 20000; c++) begin
      rst    = ($urandom_range(1499) != 0);
      tready = ($urandom_range(3) != 0);
      stop   = ($urandom_range(39) == 0);
      start  = m_active ? ($urandom_range(15) == 0) : ($urandom_range(3) == 0);
      if (!m_active || $urandom_range(7) == 0) begin
        period      = 32'($urandom_range(12));
        pulse_width = 16'($urandom_range(6));
        n_pulses    = 32'($urandom_range(4));
        amplitude   = 14'($urandom);
        baseline    = 14'($urandom);
      end
      tick();
    end
    rst = 1'b1; start = 1'b0; stop = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
